// File: rtl/timer_sched.sv
// Round-robin scheduler that shares one oneshot up-count timer among NREQ requesters,
// handing out grants, tracking expiry and draining the timer on owner cancel.
module timer_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] dur,
    input  logic [NREQ-1:0]   cancel,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [PW-1:0]     owner,
    output logic              tmr_trig,
    output logic [W-1:0]      tmr_cfg_max,
    input  logic [W-1:0]      tmr_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            trig_q, trig_d;
    logic [W-1:0]    cfg_q, cfg_d;
    logic [PW-1:0]   rr_q, rr_d;

    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [W-1:0]    win_dur;
    logic [PW-1:0]   rr_nxt;
    logic            expired;
    logic            own_cancel;

    // Scan from NREQ-1 down to 0 so the lowest offset from rr_q is the final winner.
    always_comb begin
        int idx;
        int nxt;
        idx     = 0;
        nxt     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        win_dur = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = k + int'(rr_q);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
                win_dur = dur[idx*W +: W];
            end
        end
        nxt = int'(win_idx) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        rr_nxt = PW'(nxt);
    end

    assign expired    = (tmr_cnt != '0) && (tmr_cnt >= cfg_q);
    assign own_cancel = cancel[owner_q];

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        done_d  = '0;
        trig_d  = 1'b0;
        owner_d = owner_q;
        cfg_d   = cfg_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                // Never retrigger until the timer is back at zero.
                if (win_vld && (tmr_cnt == '0)) begin
                    state_d          = S_LOAD;
                    ack_d[win_idx]   = 1'b1;
                    owner_d          = win_idx;
                    trig_d           = 1'b1;
                    cfg_d            = (win_dur == '0) ? ONE : win_dur;
                    rr_d             = rr_nxt;
                end
            end
            S_LOAD: begin
                if (own_cancel) begin
                    state_d = S_DRAIN;
                    cfg_d   = ONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The done pulse cycle stays in RUN; IDLE follows on the next edge.
                if (done_q != '0) begin
                    state_d = S_IDLE;
                end else if (expired) begin
                    done_d[owner_q] = 1'b1;
                end else if (own_cancel) begin
                    state_d = S_DRAIN;
                    cfg_d   = ONE;
                end
            end
            S_DRAIN: begin
                if (tmr_cnt == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            trig_q  <= 1'b0;
            cfg_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            trig_q  <= trig_d;
            cfg_q   <= cfg_d;
            rr_q    <= rr_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign tmr_trig    = trig_q;
    assign tmr_cfg_max = cfg_q;

endmodule
